elevator_scan_ctrl: RTL and testbench

//  Parametrised successor of the single-car elevator FSM. Latches cab calls plus directional hall calls,

---
 rtl/elevator_pkg.sv | 29 ++
 rtl/elevator_req_bank.sv | 52 +++++
 rtl/elevator_scan_ctrl.sv | 178 +++++++++++++++++
 tb/tb_elevator_scan_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared types and floor-mask helpers for the SCAN elevator controller.
package elevator_pkg;

   localparam int MAX_FLOORS = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MOVE = 2'd1,
      ST_EVAL = 2'd2,
      ST_DOOR = 2'd3
   } state_e;

   typedef enum logic {
      DIR_UP = 1'b0,
      DIR_DN = 1'b1
   } dir_e;

   // Floors strictly above pos; callers truncate to their own floor count.
   function automatic logic [MAX_FLOORS-1:0] above_mask(input int unsigned pos);
      logic [MAX_FLOORS-1:0] m;
      m = {MAX_FLOORS{1'b1}} << pos;
      return m << 1;
   endfunction

   function automatic logic [MAX_FLOORS-1:0] below_mask(input int unsigned pos);
      return ~({MAX_FLOORS{1'b1}} << pos);
   endfunction

endpackage

// File: rtl/elevator_req_bank.sv
// Cab / hall-up / hall-down call latches with reductions relative to the car position.
import elevator_pkg::*;

module elevator_req_bank #(
   parameter int FLOORS = 5,
   parameter int POS_W  = 3
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [FLOORS-1:0] cab_set_i,
   input  logic [FLOORS-1:0] up_set_i,
   input  logic [FLOORS-1:0] dn_set_i,
   input  logic [FLOORS-1:0] cab_clr_i,
   input  logic [FLOORS-1:0] up_clr_i,
   input  logic [FLOORS-1:0] dn_clr_i,
   input  logic [POS_W-1:0]  pos_i,
   output logic [FLOORS-1:0] pending_o,
   output logic              cab_at_o,
   output logic              up_at_o,
   output logic              dn_at_o,
   output logic              any_at_o,
   output logic              any_above_o,
   output logic              any_below_o
);

   logic [FLOORS-1:0] cab_q, up_q, dn_q;
   logic [FLOORS-1:0] above_m, below_m;

   // Set has priority over clear; the top masks sets when a clear must win.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cab_q <= '0;
         up_q  <= '0;
         dn_q  <= '0;
      end else begin
         cab_q <= (cab_q & ~cab_clr_i) | cab_set_i;
         up_q  <= (up_q  & ~up_clr_i)  | up_set_i;
         dn_q  <= (dn_q  & ~dn_clr_i)  | dn_set_i;
      end
   end

   assign above_m     = FLOORS'(above_mask(32'(pos_i)));
   assign below_m     = FLOORS'(below_mask(32'(pos_i)));
   assign pending_o   = cab_q | up_q | dn_q;
   assign cab_at_o    = cab_q[pos_i];
   assign up_at_o     = up_q[pos_i];
   assign dn_at_o     = dn_q[pos_i];
   assign any_at_o    = pending_o[pos_i];
   assign any_above_o = |(pending_o & above_m);
   assign any_below_o = |(pending_o & below_m);

endmodule

// File: rtl/elevator_scan_ctrl.sv
// Single-car SCAN controller: travel/door timing, door hold/re-open and emergency-stop freeze.
import elevator_pkg::*;

module elevator_scan_ctrl #(
   parameter int FLOORS      = 5,
   parameter int POS_W       = 3,
   parameter int MOVE_CYCLES = 4,
   parameter int DOOR_CYCLES = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [FLOORS-1:0] cab_req,
   input  logic [FLOORS-1:0] hall_up,
   input  logic [FLOORS-1:0] hall_dn,
   input  logic              door_hold,
   input  logic              estop,
   output logic [POS_W-1:0]  floor_pos,
   output logic              door_open,
   output logic              moving_up,
   output logic              moving_dn,
   output logic [FLOORS-1:0] pending
);

   localparam int CNT_MAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0]  MOVE_LAST = CNT_W'(MOVE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  DOOR_LAST = CNT_W'(DOOR_CYCLES - 1);
   localparam logic [POS_W-1:0]  TOP       = POS_W'(FLOORS - 1);
   localparam logic [FLOORS-1:0] UP_OK     = {1'b0, {(FLOORS-1){1'b1}}};
   localparam logic [FLOORS-1:0] DN_OK     = {{(FLOORS-1){1'b1}}, 1'b0};

   state_e            state_q, state_d;
   dir_e              dir_q, dir_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [POS_W-1:0]  pos_q, pos_d;
   logic              door_q, up_q, dn_q;

   logic [FLOORS-1:0] here, call_vec, sup;
   logic [FLOORS-1:0] cab_clr, up_clr, dn_clr;
   logic              cab_at, up_at, dn_at, any_at, any_above, any_below;
   logic              call_here, stop;

   assign here      = FLOORS'(1) << pos_q;
   assign call_vec  = cab_req | (hall_up & UP_OK) | (hall_dn & DN_OK);
   assign call_here = |(call_vec & here);
   // A call for the open-door floor re-opens the door instead of being latched.
   assign sup       = (state_q == ST_DOOR && !estop) ? here : '0;

   elevator_req_bank #(
      .FLOORS (FLOORS),
      .POS_W  (POS_W)
   ) u_bank (
      .clk_i       (clk),
      .rst_ni      (reset),
      .cab_set_i   (cab_req & ~sup),
      .up_set_i    (hall_up & UP_OK & ~sup),
      .dn_set_i    (hall_dn & DN_OK & ~sup),
      .cab_clr_i   (cab_clr),
      .up_clr_i    (up_clr),
      .dn_clr_i    (dn_clr),
      .pos_i       (pos_q),
      .pending_o   (pending),
      .cab_at_o    (cab_at),
      .up_at_o     (up_at),
      .dn_at_o     (dn_at),
      .any_at_o    (any_at),
      .any_above_o (any_above),
      .any_below_o (any_below)
   );

   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      cnt_d   = cnt_q;
      pos_d   = pos_q;
      cab_clr = '0;
      up_clr  = '0;
      dn_clr  = '0;
      stop    = 1'b0;
      if (!estop) begin
         unique case (state_q)
            ST_IDLE: begin
               cnt_d = '0;
               if (any_at) begin
                  state_d = ST_DOOR;
                  cab_clr = here;
                  up_clr  = here;
                  dn_clr  = here;
               end else if (dir_q == DIR_UP && any_above) begin
                  state_d = ST_MOVE;
               end else if (any_below) begin
                  state_d = ST_MOVE;
                  dir_d   = DIR_DN;
               end else if (any_above) begin
                  state_d = ST_MOVE;
                  dir_d   = DIR_UP;
               end
            end
            ST_MOVE: begin
               if (cnt_q == MOVE_LAST) begin
                  cnt_d   = '0;
                  state_d = ST_EVAL;
                  if (dir_q == DIR_UP) begin
                     if (pos_q != TOP) pos_d = pos_q + 1'b1;
                  end else if (pos_q != '0) begin
                     pos_d = pos_q - 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_EVAL: begin
               cnt_d = '0;
               // Opposite-direction call is only taken here when the car reverses.
               if (dir_q == DIR_UP) begin
                  stop = cab_at | up_at | (!any_above & any_at) | (pos_q == TOP);
                  if (stop) begin
                     cab_clr = here;
                     up_clr  = here;
                     if (!any_above) begin
                        dn_clr = here;
                        dir_d  = DIR_DN;
                     end
                  end
               end else begin
                  stop = cab_at | dn_at | (!any_below & any_at) | (pos_q == '0);
                  if (stop) begin
                     cab_clr = here;
                     dn_clr  = here;
                     if (!any_below) begin
                        up_clr = here;
                        dir_d  = DIR_UP;
                     end
                  end
               end
               state_d = !stop ? ST_MOVE : (any_at ? ST_DOOR : ST_IDLE);
            end
            ST_DOOR: begin
               if (door_hold || call_here) begin
                  cnt_d = '0;
               end else if (cnt_q == DOOR_LAST) begin
                  cnt_d   = '0;
                  state_d = ST_IDLE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         dir_q   <= DIR_UP;
         cnt_q   <= '0;
         pos_q   <= '0;
         door_q  <= 1'b0;
         up_q    <= 1'b0;
         dn_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         cnt_q   <= cnt_d;
         pos_q   <= pos_d;
         door_q  <= (state_d == ST_DOOR);
         up_q    <= !estop && (state_d == ST_MOVE || state_d == ST_EVAL) && dir_d == DIR_UP;
         dn_q    <= !estop && (state_d == ST_MOVE || state_d == ST_EVAL) && dir_d == DIR_DN;
      end
   end

   assign floor_pos = pos_q;
   assign door_open = door_q;
   assign moving_up = up_q;
   assign moving_dn = dn_q;

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Directed bench: expected stops are queued by the stimulus, a monitor checks each door opening.
module tb_elevator_scan_ctrl;

   localparam int FLOORS = 5;

   logic              clk, reset, door_hold, estop;
   logic [FLOORS-1:0] cab_req, hall_up, hall_dn, pending;
   logic [2:0]        floor_pos;
   logic              door_open, moving_up, moving_dn;

   int cyc   = 0;
   int nchk  = 0;
   int nfail = 0;

   typedef struct {
      int floor;
      int cyc;
      int len;
   } exp_t;

   exp_t sb[$];
   exp_t cur;
   bit   in_door = 0;
   int   dlen    = 0;

   elevator_scan_ctrl #(
      .FLOORS      (5),
      .POS_W       (3),
      .MOVE_CYCLES (2),
      .DOOR_CYCLES (3)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cab_req   (cab_req),
      .hall_up   (hall_up),
      .hall_dn   (hall_dn),
      .door_hold (door_hold),
      .estop     (estop),
      .floor_pos (floor_pos),
      .door_open (door_open),
      .moving_up (moving_up),
      .moving_dn (moving_dn),
      .pending   (pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s got=%0d exp=%0d (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   // Monitor: each door opening consumes one queued expectation.
   always @(negedge clk) begin
      if (door_open && !in_door) begin
         in_door = 1;
         dlen    = 1;
         chk("stop_expected", sb.size() > 0, 1);
         if (sb.size() > 0) begin
            cur = sb.pop_front();
            chk("stop_floor", floor_pos, cur.floor);
            if (cur.cyc >= 0) chk("stop_cycle", cyc, cur.cyc);
         end else begin
            cur = '{-1, -1, -1};
         end
      end else if (door_open) begin
         dlen++;
      end else if (in_door) begin
         in_door = 0;
         if (cur.len >= 0) chk("door_len", dlen, cur.len);
      end
   end

   task automatic wait_to(input int k);
      while (cyc < k) @(negedge clk);
   endtask

   task automatic wait_floor(input int f);
      int n = 0;
      while (int'(floor_pos) != f && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("reach_floor", floor_pos, f);
   endtask

   task automatic wait_door();
      int n = 0;
      while (!door_open && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("door_opened", door_open, 1);
   endtask

   task automatic wait_quiet();
      int n = 0;
      while ((door_open || moving_up || moving_dn || pending != 0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("quiet", !(door_open || moving_up || moving_dn || pending != 0), 1);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      int e;
      reset = 0; cab_req = '0; hall_up = '0; hall_dn = '0; door_hold = 0; estop = 0;
      repeat (3) @(negedge clk);
      chk("rst_floor", floor_pos, 0);
      chk("rst_door", door_open, 0);
      chk("rst_up", moving_up, 0);
      chk("rst_dn", moving_dn, 0);
      chk("rst_pending", pending, 0);
      reset = 1;
      @(negedge clk);

      // Single cab call to floor 3: timing of motion and door.
      t = cyc + 1;
      sb.push_back('{3, t + 10, 3});
      cab_req = 5'b01000;
      @(negedge clk);
      cab_req = '0;
      chk("t1_latched", pending, 5'b01000);
      chk("t1_not_yet_moving", moving_up, 0);
      wait_to(t + 1); chk("t1_moving_up", moving_up, 1);
      wait_to(t + 3); chk("t1_floor1", floor_pos, 1);
      wait_to(t + 9); chk("t1_floor3", floor_pos, 3);
      wait_to(t + 13);
      chk("t1_door_closed", door_open, 0);
      chk("t1_pending_clear", pending, 0);

      // Back to floor 0, then up[1] and dn[2] together.
      reset = 0;
      @(negedge clk);
      reset = 1;
      chk("t2_reset_floor", floor_pos, 0);
      sb.push_back('{1, -1, 3});
      sb.push_back('{2, -1, 3});
      hall_up = 5'b00010; hall_dn = 5'b00100;
      @(negedge clk);
      hall_up = '0; hall_dn = '0;
      chk("t2_latched", pending, 5'b00110);
      wait_quiet();
      chk("t2_end_floor", floor_pos, 2);

      // SCAN order: go to 4, calls below added en route, served on the way down.
      sb.push_back('{4, -1, 3});
      sb.push_back('{2, -1, 3});
      sb.push_back('{1, -1, 3});
      cab_req = 5'b10000;
      @(negedge clk);
      cab_req = '0;
      wait_floor(3);
      hall_dn = 5'b00100; cab_req = 5'b00010;
      @(negedge clk);
      hall_dn = '0; cab_req = '0;
      chk("t3_pending", pending, 5'b10110);
      wait_quiet();
      chk("t3_end_floor", floor_pos, 1);

      // Door hold for 4 cycles then a same-floor call re-opens without latching.
      sb.push_back('{2, -1, 8});
      cab_req = 5'b00100;
      @(negedge clk);
      cab_req = '0;
      wait_door();
      e = cyc;
      door_hold = 1;
      wait_to(e + 4);
      door_hold = 0; cab_req = 5'b00100;
      wait_to(e + 5);
      cab_req = '0;
      chk("t4_not_latched", pending, 0);
      chk("t4_door_held", door_open, 1);
      wait_to(e + 8);
      chk("t4_door_closed", door_open, 0);
      wait_quiet();
      chk("t4_end_floor", floor_pos, 2);

      // Emergency stop for 5 cycles mid-move delays arrival by exactly 5.
      t = cyc + 1;
      sb.push_back('{4, t + 12, 3});
      cab_req = 5'b10000;
      @(negedge clk);
      cab_req = '0;
      wait_to(t + 1); chk("t5_moving", moving_up, 1);
      estop = 1;
      wait_to(t + 2); chk("t5_frozen_up", moving_up, 0);
      wait_to(t + 6);
      chk("t5_frozen_floor", floor_pos, 2);
      chk("t5_frozen_up2", moving_up, 0);
      estop = 0;
      wait_to(t + 7); chk("t5_resumed", moving_up, 1);
      wait_to(t + 8); chk("t5_floor3", floor_pos, 3);
      wait_quiet();
      chk("t5_end_floor", floor_pos, 4);

      // Ignored hall bits, then reset while the door is open at floor 4.
      hall_up = 5'b10000; hall_dn = 5'b00001;
      @(negedge clk);
      hall_up = '0; hall_dn = '0;
      chk("t6_ignored_bits", pending, 0);
      repeat (4) @(negedge clk);
      chk("t6_still_idle", door_open, 0);
      sb.push_back('{4, -1, -1});
      cab_req = 5'b10000;
      @(negedge clk);
      cab_req = '0;
      wait_door();
      cab_req = 5'b00010;
      @(negedge clk);
      cab_req = '0;
      chk("t6_latched", pending, 5'b00010);
      chk("t6_door_open", door_open, 1);
      reset = 0;
      @(negedge clk);
      chk("t6_rst_floor", floor_pos, 0);
      chk("t6_rst_door", door_open, 0);
      chk("t6_rst_pending", pending, 0);
      chk("t6_rst_dn", moving_dn, 0);
      reset = 1;
      repeat (3) @(negedge clk);

      chk("sb_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
